sevenseg_rx: RTL and testbench

SEVENSEG_RX -- requirements
Module: sevenseg_rx

---
 rtl/sevenseg_rx.sv | 146 ++++++++++++++
 tb/tb_sevenseg_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sevenseg_rx.sv
// sevenseg_rx: receives a multiplexed two-digit seven-segment drive from
// asynchronous pins, debounces it, decodes the hex glyph and keeps one value
// per digit with a staleness timeout.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   pmod_in     in   [6:0] segments a..g active-low, [7] select (1=ones, 0=tens)
//   ones        out  last hex value captured with select=1
//   tens        out  last hex value captured with select=0
//   ones_valid  out  ones captured fewer than TIMEOUT cycles ago
//   tens_valid  out  tens captured fewer than TIMEOUT cycles ago
//   update      out  one-cycle pulse: a digit changed value or its valid rose
//   err         out  one-cycle pulse: stable non-blank pattern is not a glyph
module sevenseg_rx #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pmod_in,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       ones_valid,
  output logic       tens_valid,
  output logic       update,
  output logic       err
);

  localparam logic [3:0]  STABLE = 4'(STABLE_CYCLES);
  localparam logic [15:0] TMO    = 16'(TIMEOUT);

  logic [7:0]  r_sync1, r_sync2, r_prev;
  logic [3:0]  r_run;
  logic [3:0]  r_ones, r_tens;
  logic        r_ones_valid, r_tens_valid;
  logic [15:0] r_ones_tmr, r_tens_tmr;
  logic        r_update, r_err;

  logic        w_changed;
  logic [3:0]  w_run_next;
  logic        w_reach;
  logic        w_blank;
  logic [6:0]  w_seg;
  logic        w_match;
  logic [3:0]  w_digit;
  logic        w_good, w_bad;
  logic        w_wr_ones, w_wr_tens;

  // r_prev holds S from the previous edge, so a run is measured purely on S.
  assign w_changed  = (r_sync2 != r_prev);
  assign w_run_next = w_changed ? 4'd1 : ((r_run == 4'hF) ? 4'hF : r_run + 4'd1);
  // Fires once per run: either a fresh run that already meets the threshold,
  // or the single increment that lands on it (a saturated run cannot re-land).
  assign w_reach    = (w_run_next == STABLE) && (w_changed || (r_run != STABLE));

  assign w_blank = (r_sync2[6:0] == 7'h7F);
  assign w_seg   = ~r_sync2[6:0];

  always_comb begin
    w_match = 1'b1;
    w_digit = '0;
    case (w_seg)
      7'h3F: w_digit = 4'h0;
      7'h06: w_digit = 4'h1;
      7'h5B: w_digit = 4'h2;
      7'h4F: w_digit = 4'h3;
      7'h66: w_digit = 4'h4;
      7'h6D: w_digit = 4'h5;
      7'h7D: w_digit = 4'h6;
      7'h07: w_digit = 4'h7;
      7'h7F: w_digit = 4'h8;
      7'h6F: w_digit = 4'h9;
      7'h77: w_digit = 4'hA;
      7'h7C: w_digit = 4'hB;
      7'h39: w_digit = 4'hC;
      7'h5E: w_digit = 4'hD;
      7'h79: w_digit = 4'hE;
      7'h71: w_digit = 4'hF;
      default: w_match = 1'b0;
    endcase
  end

  assign w_good    = w_reach && !w_blank && w_match;
  assign w_bad     = w_reach && !w_blank && !w_match;
  assign w_wr_ones = w_good && r_sync2[7];
  assign w_wr_tens = w_good && !r_sync2[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_run   <= '0;
      r_update <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sync1 <= pmod_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_run   <= w_run_next;
      r_err   <= w_bad;
      r_update <= (w_wr_ones && ((r_ones != w_digit) || !r_ones_valid)) ||
                  (w_wr_tens && ((r_tens != w_digit) || !r_tens_valid));
    end
  end

  // A capture on the expiry edge takes priority, so valid never drops then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ones       <= '0;
      r_ones_valid <= 1'b0;
      r_ones_tmr   <= '0;
    end else if (w_wr_ones) begin
      r_ones       <= w_digit;
      r_ones_valid <= 1'b1;
      r_ones_tmr   <= TMO;
    end else if (r_ones_valid && (r_ones_tmr != '0)) begin
      r_ones_tmr <= r_ones_tmr - 16'd1;
      if (r_ones_tmr == 16'd1) r_ones_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tens       <= '0;
      r_tens_valid <= 1'b0;
      r_tens_tmr   <= '0;
    end else if (w_wr_tens) begin
      r_tens       <= w_digit;
      r_tens_valid <= 1'b1;
      r_tens_tmr   <= TMO;
    end else if (r_tens_valid && (r_tens_tmr != '0)) begin
      r_tens_tmr <= r_tens_tmr - 16'd1;
      if (r_tens_tmr == 16'd1) r_tens_valid <= 1'b0;
    end
  end

  assign ones       = r_ones;
  assign tens       = r_tens;
  assign ones_valid = r_ones_valid;
  assign tens_valid = r_tens_valid;
  assign update     = r_update;
  assign err        = r_err;

endmodule

// File: tb/tb_sevenseg_rx.sv
// tb_sevenseg_rx: directed-vector bench for sevenseg_rx (STABLE_CYCLES=2,
// TIMEOUT=16). Expected values are hand-derived from the glyph table and the
// sync/run/capture timing.
module tb_sevenseg_rx;

  logic       clk;
  logic       rst;
  logic [7:0] pmod_in;
  logic [3:0] ones, tens;
  logic       ones_valid, tens_valid, update, err;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int base_upd, base_err;

  logic [7:0] drv_tbl [8];

  sevenseg_rx #(.STABLE_CYCLES(2), .TIMEOUT(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pmod_in    (pmod_in),
    .ones       (ones),
    .tens       (tens),
    .ones_valid (ones_valid),
    .tens_valid (tens_valid),
    .update     (update),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update === 1'b1) upd_cnt++;
    if (err === 1'b1) err_cnt++;
    if (update === 1'b1 && err === 1'b1) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drv_tbl[0] = 8'h92; drv_tbl[1] = 8'h92; drv_tbl[2] = 8'hFF; drv_tbl[3] = 8'h7F;
    drv_tbl[4] = 8'h30; drv_tbl[5] = 8'h30; drv_tbl[6] = 8'h7F; drv_tbl[7] = 8'hFF;

    rst = 1'b1;
    pmod_in = 8'hFF;
    step(2);
    check_eq("rst_ones", 32'(ones), 32'h0);
    check_eq("rst_tens", 32'(tens), 32'h0);
    check_eq("rst_valids", 32'({ones_valid, tens_valid}), 32'h0);
    check_eq("rst_pulses", 32'({update, err}), 32'h0);

    // Hold ones '5' from edge 0; capture lands on edge 4.
    base_upd = upd_cnt;
    rst = 1'b0;
    pmod_in = 8'h92;
    step(3);
    check_eq("lat_e3_valid", 32'(ones_valid), 32'h0);
    check_eq("lat_e3_update", 32'(update), 32'h0);
    step(1);
    check_eq("lat_e4_ones", 32'(ones), 32'h5);
    check_eq("lat_e4_valid", 32'(ones_valid), 32'h1);
    check_eq("lat_e4_update", 32'(update), 32'h1);
    check_eq("lat_e4_tensv", 32'(tens_valid), 32'h0);

    // Go blank; valid must drop exactly 16 edges after the capture edge.
    pmod_in = 8'hFF;
    step(1);
    check_eq("lat_e5_update", 32'(update), 32'h0);
    step(14);
    check_eq("tmo_e19_valid", 32'(ones_valid), 32'h1);
    step(1);
    check_eq("tmo_e20_valid", 32'(ones_valid), 32'h0);
    check_eq("tmo_ones_hold", 32'(ones), 32'h5);
    check_eq("tmo_upd_cnt", 32'(upd_cnt - base_upd), 32'h1);
    check_eq("tmo_tensv", 32'(tens_valid), 32'h0);

    // Segment a only: not a glyph -> one err pulse, nothing else moves.
    base_upd = upd_cnt;
    base_err = err_cnt;
    pmod_in = 8'hFE;
    step(3);
    pmod_in = 8'hFF;
    step(1);
    check_eq("bad_err_e4", 32'(err), 32'h1);
    step(6);
    check_eq("bad_err_cnt", 32'(err_cnt - base_err), 32'h1);
    check_eq("bad_upd_cnt", 32'(upd_cnt - base_upd), 32'h0);
    check_eq("bad_ones", 32'(ones), 32'h5);
    check_eq("bad_valids", 32'({ones_valid, tens_valid}), 32'h0);

    // One-cycle glitch between blanks must not capture.
    base_upd = upd_cnt;
    base_err = err_cnt;
    pmod_in = 8'h92;
    step(1);
    pmod_in = 8'hFF;
    step(8);
    check_eq("glitch_upd", 32'(upd_cnt - base_upd), 32'h0);
    check_eq("glitch_err", 32'(err_cnt - base_err), 32'h0);
    check_eq("glitch_valid", 32'(ones_valid), 32'h0);

    // Multiplexed drive, 100 frames, from a fresh reset.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    base_upd = upd_cnt;
    base_err = err_cnt;
    for (int i = 0; i < 100; i++) begin
      for (int j = 0; j < 8; j++) begin
        pmod_in = drv_tbl[j];
        step(1);
      end
    end
    check_eq("mux_ones", 32'(ones), 32'h5);
    check_eq("mux_tens", 32'(tens), 32'h3);
    check_eq("mux_valids", 32'({ones_valid, tens_valid}), 32'h3);
    check_eq("mux_upd_cnt", 32'(upd_cnt - base_upd), 32'h2);
    check_eq("mux_err_cnt", 32'(err_cnt - base_err), 32'h0);

    // Value changes while valid: ones -> 1, then tens -> A.
    base_upd = upd_cnt;
    pmod_in = 8'hF9;
    step(6);
    check_eq("chg_ones", 32'(ones), 32'h1);
    pmod_in = 8'h08;
    step(6);
    check_eq("chg_tens", 32'(tens), 32'hA);
    check_eq("chg_upd_cnt", 32'(upd_cnt - base_upd), 32'h2);
    check_eq("chg_valids", 32'({ones_valid, tens_valid}), 32'h3);

    // Reset mid-run of tens '3': asynchronous clear, then a full fresh run.
    pmod_in = 8'h30;
    step(3);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_digits", 32'({ones, tens}), 32'h0);
    check_eq("arst_valids", 32'({ones_valid, tens_valid}), 32'h0);
    check_eq("arst_pulses", 32'({update, err}), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    step(3);
    check_eq("rel_e3_tensv", 32'(tens_valid), 32'h0);
    check_eq("rel_e3_tens", 32'(tens), 32'h0);
    step(1);
    check_eq("rel_e4_tens", 32'(tens), 32'h3);
    check_eq("rel_e4_tensv", 32'(tens_valid), 32'h1);
    check_eq("rel_e4_update", 32'(update), 32'h1);
    check_eq("rel_e4_onesv", 32'(ones_valid), 32'h0);
    step(2);
    check_eq("never_both", 32'(both_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
